// File: rtl/sram_byte_bridge.sv
// sram_byte_bridge: rc2014 8-bit memory bus onto a 16-bit asynchronous SRAM.
// Byte writes are read-modify-write of the whole word because the SRAM has no byte enables.
// All SRAM strobes are registered, so they come straight from flops with no decode glitches.
// Optional feature macro: SRAM_RD_CACHE_EN adds a one-word read cache (valid, tag, word).
module sram_byte_bridge #(
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned WE_WIDTH = 2,
    parameter int unsigned TURN     = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        we,
    input  logic [19:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        busy,
    output logic [18:0] sram_adr,
    output logic [15:0] sram_dat_o,
    input  logic [15:0] sram_dat_i,
    output logic        sram_dat_oe,
    output logic        sram_cs_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_TURN, S_WSET, S_WPULSE, S_WHOLD, S_ACK
    } state_t;

    localparam int unsigned     CW        = 8;
    localparam logic [CW-1:0]   RD_LAST   = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0]   WE_LAST   = CW'(WE_WIDTH - 1);
    localparam logic [CW-1:0]   TURN_LAST = CW'(TURN - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_we, r_lane;
    logic [7:0]    r_wdata, r_rdata;
    logic [15:0]   r_word, r_dat_o;
    logic [18:0]   r_adr;
    logic          r_ack, r_busy, r_cs_n, r_oe_n, r_we_n, r_dat_oe;
    logic          w_cs_n_nxt, w_oe_n_nxt, w_we_n_nxt, w_dat_oe_nxt;
    logic          w_rd_last, w_rd_hit, w_wr_hit;
    logic [15:0]   w_cache_word, w_m_word, w_merged;
    logic [7:0]    w_m_byte, w_rd_byte;
    logic          w_m_lane;

    assign w_rd_last = (r_state == S_RD) && (r_cnt == RD_LAST);

    // In IDLE the merge/read source is the cache and the live inputs; later it is the latched
    // request, with the SRAM bus used directly on the capture cycle so RD can feed WSET/ACK.
    assign w_m_word  = (r_state == S_IDLE) ? w_cache_word : (w_rd_last ? sram_dat_i : r_word);
    assign w_m_byte  = (r_state == S_IDLE) ? wdata   : r_wdata;
    assign w_m_lane  = (r_state == S_IDLE) ? addr[0] : r_lane;
    assign w_merged  = w_m_lane ? {w_m_byte, w_m_word[7:0]} : {w_m_word[15:8], w_m_byte};
    assign w_rd_byte = w_m_lane ? w_m_word[15:8] : w_m_word[7:0];

`ifdef SRAM_RD_CACHE_EN
    logic        r_cv;
    logic [18:0] r_ctag;
    logic [15:0] r_cword;
    logic        w_hit;

    assign w_hit        = r_cv && (r_ctag == addr[19:1]);
    assign w_rd_hit     = w_hit && !we;
    assign w_wr_hit     = w_hit && we;
    assign w_cache_word = r_cword;

    // Cache fill on every SRAM read capture, update with the merged word on write completion
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cv    <= 1'b0;
            r_ctag  <= '0;
            r_cword <= '0;
        end else if (w_rd_last) begin
            r_cv    <= 1'b1;
            r_ctag  <= r_adr;
            r_cword <= sram_dat_i;
        end else if (r_state == S_WHOLD) begin
            r_cv    <= 1'b1;
            r_ctag  <= r_adr;
            r_cword <= r_dat_o;
        end
    end
`else
    assign w_rd_hit     = 1'b0;
    assign w_wr_hit     = 1'b0;
    assign w_cache_word = '0;
`endif

    // State register and phase counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic and strobe levels for the state being entered
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_cnt_nxt = '0;
                    if (w_rd_hit)      w_state_nxt = S_ACK;
                    else if (w_wr_hit) w_state_nxt = (TURN == 0) ? S_WSET : S_TURN;
                    else               w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (w_rd_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = !r_we ? S_ACK : ((TURN == 0) ? S_WSET : S_TURN);
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_TURN: begin
                if (r_cnt == TURN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WSET;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WSET: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WPULSE;
            end
            S_WPULSE: begin
                if (r_cnt == WE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WHOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WHOLD: w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        w_cs_n_nxt   = 1'b1;
        w_oe_n_nxt   = 1'b1;
        w_we_n_nxt   = 1'b1;
        w_dat_oe_nxt = 1'b0;
        case (w_state_nxt)
            S_RD: begin
                w_cs_n_nxt = 1'b0;
                w_oe_n_nxt = 1'b0;
            end
            S_WSET, S_WHOLD: begin
                w_cs_n_nxt   = 1'b0;
                w_dat_oe_nxt = 1'b1;
            end
            S_WPULSE: begin
                w_cs_n_nxt   = 1'b0;
                w_we_n_nxt   = 1'b0;
                w_dat_oe_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs, request capture and datapath
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cs_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_dat_oe <= 1'b0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_adr    <= '0;
            r_dat_o  <= '0;
            r_rdata  <= '0;
            r_we     <= 1'b0;
            r_lane   <= 1'b0;
            r_wdata  <= '0;
            r_word   <= '0;
        end else begin
            r_cs_n   <= w_cs_n_nxt;
            r_oe_n   <= w_oe_n_nxt;
            r_we_n   <= w_we_n_nxt;
            r_dat_oe <= w_dat_oe_nxt;
            r_ack    <= (w_state_nxt == S_ACK);
            r_busy   <= (w_state_nxt != S_IDLE);
            if (r_state == S_IDLE && req) begin
                r_we    <= we;
                r_lane  <= addr[0];
                r_wdata <= wdata;
                r_adr   <= addr[19:1];
            end
            if (w_rd_last)
                r_word <= sram_dat_i;
            else if (r_state == S_IDLE && req && w_wr_hit)
                r_word <= w_cache_word;
            if (w_state_nxt == S_WSET && r_state != S_WSET)
                r_dat_o <= w_merged;
            if (w_state_nxt == S_ACK && r_state != S_WHOLD)
                r_rdata <= w_rd_byte;
        end
    end

    assign rdata       = r_rdata;
    assign ack         = r_ack;
    assign busy        = r_busy;
    assign sram_adr    = r_adr;
    assign sram_dat_o  = r_dat_o;
    assign sram_dat_oe = r_dat_oe;
    assign sram_cs_n   = r_cs_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_byte_bridge.sv
// Directed testbench for sram_byte_bridge with a behavioural asynchronous SRAM model.
module tb_sram_byte_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [19:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        ack, busy;
    logic [18:0] sram_adr;
    logic [15:0] sram_dat_o, sram_dat_i;
    logic        sram_dat_oe, sram_cs_n, sram_oe_n, sram_we_n;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SRAM_RD_CACHE_EN
    localparam int CACHED_RD_LAT = 1;
    localparam logic CACHED_CS_SEEN = 1'b0;
`else
    localparam int CACHED_RD_LAT = 3;
    localparam logic CACHED_CS_SEEN = 1'b1;
`endif

    sram_byte_bridge #(.RD_WAIT(2), .WE_WIDTH(2), .TURN(1)) dut (
        .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy),
        .sram_adr(sram_adr), .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i),
        .sram_dat_oe(sram_dat_oe), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model: preloaded while reset is held, written while CS and WE are low
    logic [15:0] mem [0:524287];
    assign sram_dat_i = (!sram_cs_n && !sram_oe_n) ? mem[sram_adr] : 16'hDEAD;

    always @(posedge clk) begin
        if (!resetn) begin
            mem[19'h00000] <= 16'h1234;
            mem[19'h00008] <= 16'hBEEF;
            mem[19'h7FFFF] <= 16'hC3C3;
        end else if (!sram_cs_n && !sram_we_n && sram_dat_oe) begin
            mem[sram_adr] <= sram_dat_o;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One access; called and returns on a negedge. Cycle 0 is the cycle req is sampled.
    task automatic do_access(input logic w, input logic [19:0] a, input logic [7:0] d,
                             output int lat, output logic [7:0] rd,
                             output logic [15:0] dat_seen, output logic [18:0] adr_seen,
                             output logic cs_seen);
        int first_doe, last_doe, first_we, last_we, last_oe, n_we;
        first_doe = -1; last_doe = -1; first_we = -1; last_we = -1; last_oe = -1; n_we = 0;
        lat = -1; rd = '0; dat_seen = '0; adr_seen = '0; cs_seen = 1'b0;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req = 1'b0;
                adr_seen = sram_adr;
            end
            check_eq("oe_we_excl", {31'd0, sram_oe_n | sram_we_n}, 32'd1);
            check_eq("doe_while_oe", {31'd0, sram_dat_oe & ~sram_oe_n}, 32'd0);
            if (!sram_cs_n) cs_seen = 1'b1;
            if (!sram_oe_n) last_oe = n;
            if (sram_dat_oe) begin
                if (first_doe < 0) begin
                    first_doe = n;
                    dat_seen = sram_dat_o;
                end
                last_doe = n;
            end
            if (!sram_we_n) begin
                if (first_we < 0) first_we = n;
                last_we = n;
                n_we++;
            end
            if (ack) begin
                lat = n;
                rd = rdata;
                break;
            end
        end
        if (lat < 0) check_eq("ack_timeout", 32'd0, 32'd1);
        if (w) begin
            check_eq("we_low_cycles", n_we, 32'd2);
            check_eq("doe_before_we", first_doe, first_we - 1);
            check_eq("doe_after_we", last_doe, last_we + 1);
            check_eq("turn_gap", {31'd0, (first_doe - last_oe - 1) >= 1}, 32'd1);
        end
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic [7:0]  rd;
        logic [15:0] dat;
        logic [18:0] adr;
        logic        cs;
        int          n_ack;

        // 1: reset state
        repeat (3) @(negedge clk);
        check_eq("rst_cs_n", {31'd0, sram_cs_n}, 32'd1);
        check_eq("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check_eq("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check_eq("rst_dat_oe", {31'd0, sram_dat_oe}, 32'd0);
        check_eq("rst_ack", {31'd0, ack}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_rdata", {24'd0, rdata}, 32'd0);
        check_eq("rst_adr", {13'd0, sram_adr}, 32'd0);
        check_eq("rst_dat_o", {16'd0, sram_dat_o}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 2: RMW write into high lane of word 0, then read both lanes back
        do_access(1'b1, 20'h00001, 8'hA5, lat, rd, dat, adr, cs);
        check_eq("wr1_lat", lat, 32'd8);
        check_eq("wr1_dat_o", {16'd0, dat}, 32'h0000A534);
        check_eq("wr1_mem", {16'd0, mem[19'h00000]}, 32'h0000A534);
        check_eq("busy_after_wr", {31'd0, busy}, 32'd0);
        do_access(1'b0, 20'h00001, 8'h00, lat, rd, dat, adr, cs);
        check_eq("rd_hi_lat", lat, CACHED_RD_LAT);
        check_eq("rd_hi_data", {24'd0, rd}, 32'h000000A5);
        do_access(1'b0, 20'h00000, 8'h00, lat, rd, dat, adr, cs);
        check_eq("rd_lo_data", {24'd0, rd}, 32'h00000034);
        check_eq("rdata_held", {24'd0, rdata}, 32'h00000034);

        // 4: top address, high lane, low byte preserved
        do_access(1'b1, 20'hFFFFF, 8'h5A, lat, rd, dat, adr, cs);
        check_eq("top_lat", lat, 32'd8);
        check_eq("top_adr", {13'd0, adr}, 32'h0007FFFF);
        check_eq("top_dat_o", {16'd0, dat}, 32'h00005AC3);
        check_eq("top_mem", {16'd0, mem[19'h7FFFF]}, 32'h00005AC3);

        // 6: repeated read of the same word
        do_access(1'b0, 20'h00010, 8'h00, lat, rd, dat, adr, cs);
        check_eq("rd10_a_lat", lat, 32'd3);
        check_eq("rd10_a_data", {24'd0, rd}, 32'h000000EF);
        do_access(1'b0, 20'h00010, 8'h00, lat, rd, dat, adr, cs);
        check_eq("rd10_b_lat", lat, CACHED_RD_LAT);
        check_eq("rd10_b_cs", {31'd0, cs}, {31'd0, CACHED_CS_SEEN});
        check_eq("rd10_b_data", {24'd0, rd}, 32'h000000EF);

        // 5: reset during the write pulse abandons the access
        req = 1'b1; we = 1'b1; addr = 20'h00021; wdata = 8'h77;
        @(negedge clk);
        req = 1'b0;
        for (int n = 0; n < 20 && sram_we_n; n++) @(negedge clk);
        check_eq("wpulse_reached", {31'd0, sram_we_n}, 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        check_eq("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        check_eq("abort_cs_n", {31'd0, sram_cs_n}, 32'd1);
        check_eq("abort_dat_oe", {31'd0, sram_dat_oe}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        n_ack = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        check_eq("abort_no_ack", n_ack, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
